bitcoin_miner: RTL and testbench

BITCOIN_MINER -- requirements
Module: bitcoin_miner

---
 rtl/bitcoin_miner.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_bitcoin_miner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_miner.sv
// Bitcoin double-SHA-256 nonce sweeper with NUM_CORES parallel compression cores.
// Optional target comparison enabled by defining BITCOIN_MINER_TARGET_EN.

module simplified_sha256 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] h_in  [8],
    input  logic [31:0] block [16],
    output logic        done,
    output logic [31:0] h_out [8]
);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic        busy;
    logic [5:0]  round;
    logic [31:0] v  [8];
    logic [31:0] hb [8];
    logic [31:0] w  [16];
    logic [31:0] nv [8];
    logic [31:0] w_next;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One round per cycle; w is a 16-word sliding window of the message schedule.
    always_comb begin
        logic [31:0] t1, t2;
        t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[round] + w[0];
        t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        nv[0] = t1 + t2;
        nv[1] = v[0];
        nv[2] = v[1];
        nv[3] = v[2];
        nv[4] = v[3] + t1;
        nv[5] = v[4];
        nv[6] = v[5];
        nv[7] = v[6];
        w_next = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
               + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    end

    assign done = ~busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy  <= 1'b0;
            round <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            round <= '0;
        end else if (busy) begin
            round <= round + 6'd1;
            if (round == 6'd63) busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            hb <= h_in;
            v  <= h_in;
            w  <= block;
        end else if (busy) begin
            v <= nv;
            for (int unsigned i = 0; i < 15; i++) w[i] <= w[i + 1];
            w[15] <= w_next;
            if (round == 6'd63)
                for (int unsigned i = 0; i < 8; i++) h_out[i] <= hb[i] + nv[i];
        end
    end
endmodule

module bitcoin_miner #(
    parameter int unsigned NUM_NONCES = 16,
    parameter int unsigned NUM_CORES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    input  logic [31:0] nonce_base,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
`ifdef BITCOIN_MINER_TARGET_EN
  , input  logic [31:0] target,
    output logic        found,
    output logic [31:0] found_nonce
`endif
);
    localparam int unsigned NB = NUM_NONCES / NUM_CORES;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned WW = $clog2(NUM_NONCES + 1);
    localparam int unsigned CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    generate
        if (NUM_NONCES % NUM_CORES != 0 || NUM_NONCES < 1 || NUM_NONCES > 1024 ||
            NUM_CORES < 1 || NUM_CORES > 16) begin : g_bad_params
            $error("bitcoin_miner: NUM_NONCES must be 1..1024 and a multiple of NUM_CORES (1..16)");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, READ, BLK1, BATCH2, BATCH3, WRITE} state_t;

    state_t                 state;
    logic [4:0]             cnt;
    logic [BW-1:0]          bcnt;
    logic [WW-1:0]          wcnt;
    logic [15:0]            msg_addr, out_addr;
    logic [31:0]            nonce_cur;
    logic                   launched;
    logic [NUM_CORES-1:0]   core_start, core_done;
    logic [31:0]            core_h   [NUM_CORES][8];
    logic [31:0]            core_blk [NUM_CORES][16];
    logic [31:0]            core_out [NUM_CORES][8];
    logic [31:0]            hdr      [19];
    logic [31:0]            mid      [8];
    logic [31:0]            results  [NUM_NONCES];
    logic                   all_done;
    logic                   reset_n;

    assign mem_clk  = clk;
    assign reset_n  = ~reset;
    // Core done is stale on the cycle start is pulsed, hence the launched/start gating.
    assign all_done = launched && (core_start == '0) && (&core_done);

    always_comb begin
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            for (int unsigned i = 0; i < 8; i++) core_h[c][i] = (state == BATCH2) ? mid[i] : IV[i];
            for (int unsigned i = 0; i < 16; i++) core_blk[c][i] = '0;
            case (state)
                BATCH2: begin
                    core_blk[c][0]  = hdr[16];
                    core_blk[c][1]  = hdr[17];
                    core_blk[c][2]  = hdr[18];
                    core_blk[c][3]  = nonce_cur + c;
                    core_blk[c][4]  = 32'h8000_0000;
                    core_blk[c][15] = 32'd640;
                end
                BATCH3: begin
                    for (int unsigned i = 0; i < 8; i++) core_blk[c][i] = core_out[c][i];
                    core_blk[c][8]  = 32'h8000_0000;
                    core_blk[c][15] = 32'd256;
                end
                default: for (int unsigned i = 0; i < 16; i++) core_blk[c][i] = hdr[i];
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        simplified_sha256 u_core (
            .clk     (clk),
            .reset_n (reset_n),
            .start   (core_start[g]),
            .h_in    (core_h[g]),
            .block   (core_blk[g]),
            .done    (core_done[g]),
            .h_out   (core_out[g])
        );
    end

`ifdef BITCOIN_MINER_TARGET_EN
    logic          hit;
    logic [CW-1:0] hit_c;

    always_comb begin
        hit   = 1'b0;
        hit_c = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_out[i][0] < target) begin
                hit   = 1'b1;
                hit_c = CW'(i);
            end
        end
    end
`endif

    // Result buffer shifts down: each batch enters at the top, WRITE drains from index 0.
    always_ff @(posedge clk) begin
        if (state == READ && cnt != 5'd0) hdr[cnt - 5'd1] <= mem_read_data;
        if (state == BLK1 && all_done) mid <= core_out[0];
        if (state == BATCH3 && all_done) begin
            for (int unsigned j = 0; j < NUM_NONCES - NUM_CORES; j++) results[j] <= results[j + NUM_CORES];
            for (int unsigned c = 0; c < NUM_CORES; c++) results[NUM_NONCES - NUM_CORES + c] <= core_out[c][0];
        end else if (state == WRITE && wcnt != WW'(NUM_NONCES)) begin
            for (int unsigned j = 0; j + 1 < NUM_NONCES; j++) results[j] <= results[j + 1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            done           <= 1'b1;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            core_start     <= '0;
            launched       <= 1'b0;
            cnt            <= '0;
            bcnt           <= '0;
            wcnt           <= '0;
            msg_addr       <= '0;
            out_addr       <= '0;
            nonce_cur      <= '0;
`ifdef BITCOIN_MINER_TARGET_EN
            found          <= 1'b0;
            found_nonce    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    msg_addr  <= message_addr;
                    out_addr  <= output_addr;
                    nonce_cur <= nonce_base;
                    mem_addr  <= message_addr;
                    cnt       <= '0;
                    done      <= 1'b0;
                    state     <= READ;
`ifdef BITCOIN_MINER_TARGET_EN
                    found       <= 1'b0;
                    found_nonce <= '0;
`endif
                end
                READ: begin
                    if (cnt < 5'd18) mem_addr <= msg_addr + 16'(cnt) + 16'd1;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd19) state <= BLK1;
                end
                BLK1, BATCH2, BATCH3: begin
                    if (core_start != '0) begin
                        core_start <= '0;
                    end else if (!launched) begin
                        core_start <= (state == BLK1) ? NUM_CORES'(1) : {NUM_CORES{1'b1}};
                        launched   <= 1'b1;
                    end else if (all_done) begin
                        launched <= 1'b0;
                        case (state)
                            BLK1: begin
                                bcnt  <= '0;
                                state <= BATCH2;
                            end
                            BATCH2: state <= BATCH3;
                            default: begin
`ifdef BITCOIN_MINER_TARGET_EN
                                if (!found && hit) begin
                                    found       <= 1'b1;
                                    found_nonce <= nonce_cur + 32'(hit_c);
                                end
`endif
                                if (bcnt == BW'(NB - 1)) begin
                                    wcnt  <= '0;
                                    state <= WRITE;
                                end else begin
                                    bcnt      <= bcnt + BW'(1);
                                    nonce_cur <= nonce_cur + 32'(NUM_CORES);
                                    state     <= BATCH2;
                                end
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (wcnt == WW'(NUM_NONCES)) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        mem_we         <= 1'b1;
                        mem_addr       <= out_addr + 16'(wcnt);
                        mem_write_data <= results[0];
                        wcnt           <= wcnt + WW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitcoin_miner.sv
// Self-checking bench for bitcoin_miner: reference SHA-256 model, directed vector table,
// plus reset-abort, start-hammer and (with BITCOIN_MINER_TARGET_EN) target sequences.
`timescale 1ns/1ps
module tb_bitcoin_miner;
    typedef logic [31:0] w8_t  [8];
    typedef logic [31:0] w16_t [16];

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam w8_t IV = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [15:0] MSG = 16'h0100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] out_a = '0, out_b = '0;
    logic [31:0] base_a = '0, base_b = '0;
    logic        done_a, done_b, mclk_a, mclk_b, we_a, we_b;
    logic [15:0] addr_a, addr_b;
    logic [31:0] wd_a, wd_b, rd_a, rd_b;
    logic [31:0] target = '0;
    logic        found_a, found_b;
    logic [31:0] fnonce_a, fnonce_b;

    logic [31:0] hdr [19];
    logic [31:0] mem [65536];
    int wc_a = 0, wc_b = 0, bad19 = 0;
    int checks = 0, errors = 0;

    bitcoin_miner #(.NUM_NONCES(16), .NUM_CORES(8)) dut (
        .clk(clk), .reset(reset), .start(start_a), .message_addr(MSG), .output_addr(out_a),
        .nonce_base(base_a), .done(done_a), .mem_clk(mclk_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_write_data(wd_a), .mem_read_data(rd_a)
`ifdef BITCOIN_MINER_TARGET_EN
      , .target(target), .found(found_a), .found_nonce(fnonce_a)
`endif
    );

    bitcoin_miner #(.NUM_NONCES(4), .NUM_CORES(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .message_addr(MSG), .output_addr(out_b),
        .nonce_base(base_b), .done(done_b), .mem_clk(mclk_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_write_data(wd_b), .mem_read_data(rd_b)
`ifdef BITCOIN_MINER_TARGET_EN
      , .target(target), .found(found_b), .found_nonce(fnonce_b)
`endif
    );

    function automatic logic [31:0] fetch(input logic [15:0] a);
        if (a >= MSG && a < MSG + 16'd19) return hdr[a - MSG];
        if (a == MSG + 16'd19) return 32'hdeadbeef;
        return mem[a];
    endfunction

    always @(posedge clk) begin
        if (we_a) begin mem[addr_a] <= wd_a; wc_a <= wc_a + 1; end
        if (we_b) begin mem[addr_b] <= wd_b; wc_b <= wc_b + 1; end
        if ((!we_a && !done_a && addr_a == MSG + 16'd19) || (!we_b && !done_b && addr_b == MSG + 16'd19))
            bad19 <= bad19 + 1;
        rd_a <= fetch(addr_a);
        rd_b <= fetch(addr_b);
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic w8_t compress(input w8_t hin, input w16_t blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        w8_t r;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        {a, b, c, d, e, f, g, h} = {hin[0], hin[1], hin[2], hin[3], hin[4], hin[5], hin[6], hin[7]};
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = hin[0] + a; r[1] = hin[1] + b; r[2] = hin[2] + c; r[3] = hin[3] + d;
        r[4] = hin[4] + e; r[5] = hin[5] + f; r[6] = hin[6] + g; r[7] = hin[7] + h;
        return r;
    endfunction

    function automatic logic [31:0] golden_h0(input logic [31:0] nonce);
        w16_t blk;
        w8_t  st, dg;
        for (int i = 0; i < 16; i++) blk[i] = hdr[i];
        st = compress(IV, blk);
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = hdr[16]; blk[1] = hdr[17]; blk[2] = hdr[18]; blk[3] = nonce;
        blk[4] = 32'h80000000; blk[15] = 32'd640;
        dg = compress(st, blk);
        for (int i = 0; i < 16; i++) blk[i] = (i < 8) ? dg[i] : 32'h0;
        blk[8] = 32'h80000000; blk[15] = 32'd256;
        st = compress(IV, blk);
        return st[0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run(input logic sel, input logic [31:0] base, input logic [15:0] oaddr, input bit hammer);
        bit timed_out;
        @(negedge clk);
        if (sel) begin base_b = base; out_b = oaddr; start_b = 1'b1; end
        else     begin base_a = base; out_a = oaddr; start_a = 1'b1; end
        @(negedge clk);
        if (!hammer) begin start_a = 1'b0; start_b = 1'b0; end
        timed_out = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ((sel ? done_b : done_a) === 1'b1) begin timed_out = 1'b0; break; end
            @(negedge clk);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check("run_completes", {31'd0, timed_out}, 32'd0);
    endtask

    typedef struct {
        logic             sel;
        logic [31:0]      base;
        logic [15:0]      oaddr;
        int               n;
        logic [15:0][31:0] exp;
    } vec_t;
    vec_t vecs [5];

    task automatic check_words(input string tag, input logic [15:0] oaddr, input int n, input logic [15:0][31:0] exp);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            a = oaddr + 16'(i);
            check($sformatf("%s_word%0d", tag, i), mem[a], exp[i]);
        end
    endtask

    initial begin
        w16_t abc;
        w8_t  dabc;
        int   snap;
        for (int i = 0; i < 19; i++) hdr[i] = (32'h9e3779b9 * 32'(i + 1)) ^ 32'h0badf00d;

        for (int i = 0; i < 16; i++) abc[i] = '0;
        abc[0] = 32'h61626380; abc[15] = 32'h00000018;
        dabc = compress(IV, abc);
        check("model_sha256_abc", dabc[0], 32'hba7816bf);

        vecs[0] = '{sel: 1'b0, base: 32'h00000000, oaddr: 16'h1000, n: 16, exp: '0};
        vecs[1] = '{sel: 1'b1, base: 32'hFFFFFFFE, oaddr: 16'h2000, n: 4,  exp: '0};
        vecs[2] = '{sel: 1'b0, base: 32'hFFFFFFF8, oaddr: 16'hFFF8, n: 16, exp: '0};
        vecs[3] = '{sel: 1'b1, base: 32'h00000000, oaddr: 16'h3000, n: 4,  exp: '0};
        vecs[4] = '{sel: 1'b0, base: 32'hdeadbeef, oaddr: 16'h8000, n: 16, exp: '0};
        for (int v = 0; v < 5; v++)
            for (int i = 0; i < vecs[v].n; i++) vecs[v].exp[i] = golden_h0(vecs[v].base + 32'(i));

        @(negedge clk);
        check("reset_done", {31'd0, done_a}, 32'd1);
        check("reset_mem_we", {31'd0, we_a}, 32'd0);
        check("reset_mem_addr", {16'd0, addr_a}, 32'd0);
        check("reset_wdata", wd_a, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            snap = vecs[v].sel ? wc_b : wc_a;
            run(vecs[v].sel, vecs[v].base, vecs[v].oaddr, 1'b0);
            check_words($sformatf("vec%0d", v), vecs[v].oaddr, vecs[v].n, vecs[v].exp);
            check($sformatf("vec%0d_writes", v), 32'((vecs[v].sel ? wc_b : wc_a) - snap), 32'(vecs[v].n));
        end

        // Reset during BATCH3 of batch 0 (READ ~21 + BLK1 ~67 + BATCH2 ~67 cycles in).
        snap = wc_a;
        @(negedge clk);
        base_a = 32'h0; out_a = 16'h4000; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (180) @(negedge clk);
        check("busy_before_reset", {31'd0, done_a}, 32'd0);
        reset = 1'b1;
        #1;
        check("midrun_reset_done", {31'd0, done_a}, 32'd1);
        check("midrun_reset_we", {31'd0, we_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        check("abandoned_writes", 32'(wc_a - snap), 32'd0);
        check("abandoned_done", {31'd0, done_a}, 32'd1);
        snap = wc_a;
        run(1'b0, 32'h0, 16'h5000, 1'b0);
        check_words("restart", 16'h5000, 16, vecs[0].exp);
        check("restart_writes", 32'(wc_a - snap), 32'd16);

        // start held high for the whole run must yield exactly one run
        snap = wc_a;
        run(1'b0, 32'h0, 16'h6000, 1'b1);
        check_words("hammer", 16'h6000, 16, vecs[0].exp);
        repeat (300) @(negedge clk);
        check("hammer_writes", 32'(wc_a - snap), 32'd16);
        check("hammer_idle", {31'd0, done_a}, 32'd1);

`ifdef BITCOIN_MINER_TARGET_EN
        begin
            bit exp_found;
            int exp_idx;
            target = vecs[0].exp[5] + 32'd1;
            exp_found = 1'b0;
            exp_idx = 0;
            for (int i = 15; i >= 0; i--)
                if (vecs[0].exp[i] < target) begin exp_found = 1'b1; exp_idx = i; end
            run(1'b0, 32'h0, 16'h7000, 1'b0);
            check("found_set", {31'd0, found_a}, {31'd0, exp_found});
            check("found_nonce", fnonce_a, 32'(exp_idx));
            target = 32'h0;
            run(1'b0, 32'h0, 16'h7100, 1'b0);
            check("found_clear", {31'd0, found_a}, 32'd0);
        end
`endif

        check("word19_never_read", 32'(bad19), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end
endmodule
